inst_encoder: RTL and testbench

Encodes RV32I instruction fields (op, rd, rs1, rs2, signed immediate) into 32-bit instruction words, the inverse of the core's immediate-extraction path. Words are buffered in a small FIFO and drained over a valid/ready port. It sits between the test-program generator / self-test sequencer and the instruction-memory write port. It supports exactly the four formats the core executes: addi (I), lw (I), sw (S), beq (B).

---
 rtl/inst_encoder.sv | 121 ++++++++++++
 tb/tb_inst_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I addi/lw/sw/beq word encoder feeding a small valid/ready FIFO
// Optional immediate range checking with sticky err_o: INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [1:0]                 op_i,
  input  logic [4:0]                 rd_i,
  input  logic [4:0]                 rs1_i,
  input  logic [4:0]                 rs2_i,
  input  logic [31:0]                imm_i,
  output logic [31:0]                data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                issued_o,
  output logic                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   issued_q, issued_d;
  logic [31:0]   word;
  logic          accept, push, pop, range_bad;

  always_comb begin
    word = '0;
    case (op_i)
      2'd0: word = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b0010011};
      2'd1: word = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
      2'd2: word = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
      2'd3: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000, imm_i[4:1], imm_i[11], 7'b1100011};
      default: word = '0;
    endcase
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    range_bad = 1'b0;
    if (op_i == 2'd3) begin
      range_bad = ($signed(imm_i) < -32'sd4096) || ($signed(imm_i) > 32'sd4094) || imm_i[0];
    end else begin
      range_bad = ($signed(imm_i) < -32'sd2048) || ($signed(imm_i) > 32'sd2047);
    end
  end

  always_comb begin
    err_d = err_q | (accept & range_bad);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_imm;
  assign unused_imm = ^imm_i[31:13];
  assign range_bad  = 1'b0;
  assign err_o      = 1'b0;
`endif

  assign ready_o  = (count_q < DEPTH_C) && rst_i;
  assign valid_o  = (count_q != '0) && rst_i;
  assign data_o   = valid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign count_o  = count_q;
  assign issued_o = issued_q;

  // A rejected out-of-range word still completes its handshake; it is just never stored.
  assign accept = valid_i && ready_o;
  assign push   = accept && !range_bad;
  assign pop    = valid_o && ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    issued_d = issued_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      issued_d = issued_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed-vector bench for inst_encoder (DEPTH=4)
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, ready_i, valid_o, err_o;
  logic [1:0]  op_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i, data_o;
  logic [2:0]  count_o;
  logic [15:0] issued_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q[$];

  inst_encoder #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .issued_o(issued_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    set_fields(op, rd, rs1, rs2, imm);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    set_fields(2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_data", data_o, 32'h0);
    check("rst_issued", 32'(issued_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check("ready_after_rst", 32'(ready_o), 32'd1);

    // addi x1, x0, 5
    push(2'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    check("addi_data", data_o, 32'h00500093);
    check("addi_valid", 32'(valid_o), 32'd1);
    check("addi_count", 32'(count_o), 32'd1);
    ready_i = 1'b1; tick(); ready_i = 1'b0;
    check("addi_popped", 32'(count_o), 32'd0);
    check("addi_issued", 32'(issued_o), 32'd1);

    // lw / sw / beq buffered then drained
    push(2'd1, 5'd2, 5'd1, 5'd0, 32'd8);
    push(2'd2, 5'd0, 5'd1, 5'd2, -32'sd4);
    push(2'd3, 5'd0, 5'd1, 5'd2, -32'sd8);
    check("mix_count", 32'(count_o), 32'd3);
    ready_i = 1'b1;
    check("lw_data", data_o, 32'h0080A103);
    tick();
    check("sw_data", data_o, 32'hFE20AE23);
    tick();
    check("beq_data", data_o, 32'hFE208CE3);
    tick();
    ready_i = 1'b0;
    check("mix_empty_valid", 32'(valid_o), 32'd0);
    check("mix_empty_data", data_o, 32'h0);
    check("mix_issued", 32'(issued_o), 32'd4);

    // fill to DEPTH with addi x3, x4, k
    for (int k = 1; k <= 4; k++) begin
      push(2'd0, 5'd3, 5'd4, 5'd0, 32'(k));
      q.push_back(32'h00020193 | (32'(k) << 20));
    end
    check("full_count", 32'(count_o), 32'd4);
    check("full_ready", 32'(ready_o), 32'd0);
    set_fields(2'd0, 5'd3, 5'd4, 5'd0, 32'd99);
    valid_i = 1'b1; ready_i = 1'b1;
    tick();
    void'(q.pop_front());
    check("full_pop_count", 32'(count_o), 32'd3);
    check("full_pop_head", data_o, q[0]);

    for (int k = 0; k < 20; k++) begin
      check($sformatf("stream_%0d", k), data_o, q[0]);
      set_fields(2'd0, 5'd3, 5'd4, 5'd0, 32'(100 + k));
      tick();
      void'(q.pop_front());
      q.push_back(32'h00020193 | (32'(100 + k) << 20));
    end
    valid_i = 1'b0;
    check("stream_count", 32'(count_o), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_%0d", k), data_o, q[0]);
      tick();
      void'(q.pop_front());
    end
    ready_i = 1'b0;
    check("drain_count", 32'(count_o), 32'd0);
    check("drain_issued", 32'(issued_o), 32'd28);

    // immediate range behaviour
    push(2'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    check("range_addi_err", 32'(err_o), 32'd1);
    check("range_addi_count", 32'(count_o), 32'd0);
    push(2'd3, 5'd0, 5'd0, 5'd0, 32'd6);
    check("range_beq6_count", 32'(count_o), 32'd1);
    push(2'd3, 5'd0, 5'd0, 5'd0, 32'd3);
    check("range_beq3_err", 32'(err_o), 32'd1);
    check("range_beq3_count", 32'(count_o), 32'd1);
`else
    check("trunc_addi_data", data_o, 32'h80000013);
    check("trunc_addi_err", 32'(err_o), 32'd0);
    check("trunc_addi_count", 32'(count_o), 32'd1);
`endif
    ready_i = 1'b1; tick(); ready_i = 1'b0;

    // reset mid-stream
    for (int k = 0; k < 3; k++) push(2'd0, 5'd3, 5'd4, 5'd0, 32'(k));
    check("pre_rst_count", 32'(count_o), 32'd3);
    rst_i = 1'b0;
    tick();
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    check("mid_rst_issued", 32'(issued_o), 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    check("mid_rst_data", data_o, 32'h0);
    rst_i = 1'b1;
    push(2'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    check("post_rst_data", data_o, 32'h00500093);
    check("post_rst_count", 32'(count_o), 32'd1);

    // issued_o wrap: one push and one pop per cycle
    valid_i = 1'b1; ready_i = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    check("issued_ffff", 32'(issued_o), 32'h0000FFFF);
    tick();
    check("issued_wrap", 32'(issued_o), 32'h00000000);
    check("wrap_count", 32'(count_o), 32'd1);
    valid_i = 1'b0; ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
